// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the burst memory block: FSM states, command
// encodings and a parameter legality check.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_e;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  // Read latency must fit the tag pipeline and the buffer must absorb a full pipeline plus one.
  function automatic bit params_ok(input int unsigned rd_lat, input int unsigned buf_depth);
    return (rd_lat >= 1) && (rd_lat <= 4) && (buf_depth >= rd_lat + 1);
  endfunction

endpackage

// File: rtl/mem_ram_sp.sv
// Behavioural single-port RAM with per-byte write enables and RD_LAT output
// register stages; written to map onto block RAM.
module mem_ram_sp #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] pipe [RD_LAT];

  // Array access plus output pipeline; no reset so the storage stays RAM-mappable.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      pipe[0] <= mem[addr];
    end
    for (int s = 1; s < RD_LAT; s++) pipe[s] <= pipe[s-1];
  end

  assign rdata = pipe[RD_LAT-1];

endmodule

// File: rtl/mem_burst_sp.sv
// Burst-capable single-port memory: command FSM, address/beat counters, read tag
// pipeline and a credit-limited show-ahead return buffer in front of mem_ram_sp.
module mem_burst_sp
  import mem_burst_pkg::*;
#(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  output logic                  busy
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned INF_W  = $clog2(RD_LAT + 1);
  localparam int unsigned CRED_W = $clog2(BUF_DEPTH + RD_LAT + 1);

  if (!params_ok(RD_LAT, BUF_DEPTH)) begin : g_param_err
    $error("mem_burst_sp: RD_LAT must be 1..4 and BUF_DEPTH >= RD_LAT+1");
  end

  state_e                state, state_n;
  logic [ADDR_W-1:0]     addr_q, addr_n;
  logic [LEN_W-1:0]      beats_q, beats_n;
  logic                  issue, wr_fire, last_issue, credit_ok;
  logic [BE_W-1:0]       ram_we;
  logic [DATA_W-1:0]     ram_rdata;
  logic [RD_LAT-1:0]     tag_v, tag_last, tag_v_n, tag_last_n;
  logic [INF_W-1:0]      inflight, inflight_n;
  logic [CNT_W-1:0]      count, count_n;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_W-1:0]     buf_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  buf_last;
  logic                  exit_v, exit_last, buf_empty, push, pop_buf;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next state, counters and per-cycle RAM access decisions.
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    beats_n = beats_q;
    issue   = 1'b0;
    wr_fire = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n  = cmd_addr;
          beats_n = cmd_len;
          case (cmd_wr)
            CMD_RD: state_n = RD_BURST;
            CMD_WR: state_n = WR_BURST;
          endcase
        end
      end
      RD_BURST: begin
        if (credit_ok) begin
          issue   = 1'b1;
          addr_n  = addr_q + ADDR_W'(1);
          beats_n = beats_q - LEN_W'(1);
          if (beats_q == '0) state_n = IDLE;
        end
      end
      WR_BURST: begin
        if (wr_valid) begin
          wr_fire = 1'b1;
          addr_n  = addr_q + ADDR_W'(1);
          beats_n = beats_q - LEN_W'(1);
          if (beats_q == '0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign last_issue = issue && (beats_q == '0);
  assign ram_we     = wr_fire ? wr_be : '0;
  assign tag_v_n    = RD_LAT'({tag_v, issue});
  assign tag_last_n = RD_LAT'({tag_last, last_issue});

  // In-flight reads now and after this edge.
  always_comb begin
    inflight   = '0;
    inflight_n = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight   = inflight + INF_W'(tag_v[i]);
      inflight_n = inflight_n + INF_W'(tag_v_n[i]);
    end
  end

  assign credit_ok = (CRED_W'(count) + CRED_W'(inflight)) < CRED_W'(BUF_DEPTH);

  // Show-ahead output: an exiting beat bypasses the empty buffer when taken at once.
  assign exit_v    = tag_v[RD_LAT-1];
  assign exit_last = tag_last[RD_LAT-1];
  assign buf_empty = (count == '0);
  assign pop_buf   = !buf_empty && rd_ready;
  assign push      = exit_v && !(buf_empty && rd_ready);
  assign count_n   = count + CNT_W'(push) - CNT_W'(pop_buf);

  assign rd_valid = !buf_empty || exit_v;
  assign rd_data  = !buf_empty ? buf_data[rd_ptr] : (exit_v ? ram_rdata : '0);
  assign rd_last  = !buf_empty ? buf_last[rd_ptr] : exit_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      beats_q   <= '0;
      tag_v     <= '0;
      tag_last  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      beats_q   <= beats_n;
      tag_v     <= tag_v_n;
      tag_last  <= tag_last_n;
      count     <= count_n;
      if (push)    wr_ptr <= ptr_inc(wr_ptr);
      if (pop_buf) rd_ptr <= ptr_inc(rd_ptr);
      cmd_ready <= (state_n == IDLE);
      wr_ready  <= (state_n == WR_BURST);
      busy      <= (state_n != IDLE) || (inflight_n != '0) || (count_n != '0);
    end
  end

  // Buffer payload needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= ram_rdata;
      buf_last[wr_ptr] <= exit_last;
    end
  end

  mem_ram_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk   (clk),
    .en    (issue || wr_fire),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

endmodule
